// File: rtl/cnn_fb_loader_pkg.sv
// Shared parameters and types for the CNN filter-buffer loader slice.
// Holds the layer-wide widths (channel index, memory address/data),
// the kernel tap count, the burst limit, the loader state encoding and
// a burst-length clipping helper shared with other burst engines.
package cnn_fb_loader_pkg;

  localparam int W_CHANNEL = 5;   // tiled channel count / index width
  localparam int W_ADDR    = 32;  // external memory byte-address width
  localparam int W_DATA    = 32;  // memory / filter-buffer word width
  localparam int KTAPS     = 9;   // words per input-channel tile (3x3)
  localparam int MAX_BURST = 16;  // maximum beats per read request
  localparam int W_FB_ADDR = 9;   // filter-buffer address width
  localparam int W_LEN     = 5;   // burst length field, holds 1..MAX_BURST

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RECV = 2'd2,
    S_DONE = 2'd3
  } fb_state_e;

  // Beats for the next burst: whatever is left, capped at the burst limit.
  function automatic logic [W_LEN-1:0] clip_len(input logic [31:0] remaining,
                                               input logic [31:0] max_burst);
    if (remaining > max_burst) return W_LEN'(max_burst);
    else                       return W_LEN'(remaining);
  endfunction

endpackage

// File: rtl/cnn_burst_splitter.sv
// Splits a linear read of `total` words starting at `start_addr` into
// bounded bursts. Presents the current (addr, len) request, counts down
// the beats of the accepted burst, and advances to the next burst after
// its last beat.
//   start      : load start_addr/total (one cycle)
//   ack        : current request accepted; arms the beat countdown
//   beat       : one data word consumed
//   addr/len   : current burst request
//   burst_last : the next beat closes the current burst
//   final_word : the next beat is the last word of the whole transfer
module cnn_burst_splitter
  import cnn_fb_loader_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 9,
  parameter int MAX_LEN    = 16,
  parameter int WORD_BYTES = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  total,
  input  logic              ack,
  input  logic              beat,
  output logic [ADDR_W-1:0] addr,
  output logic [W_LEN-1:0]  len,
  output logic              burst_last,
  output logic              final_word
);

  logic [CNT_W-1:0] remaining;
  logic [W_LEN-1:0] beats_left;
  logic [CNT_W-1:0] remaining_dec;

  assign remaining_dec = remaining - CNT_W'(1);
  assign burst_last    = (beats_left == W_LEN'(1));
  assign final_word    = (remaining == CNT_W'(1));

  // NOTE: every register here is updated with <= so all of them sample the
  // pre-edge values; a blocking = would let later statements see new values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr       <= '0;
      len        <= '0;
      remaining  <= '0;
      beats_left <= '0;
    end else if (start) begin
      addr       <= start_addr;
      remaining  <= total;
      len        <= clip_len(32'(total), 32'(MAX_LEN));
      beats_left <= '0;
    end else if (ack) begin
      beats_left <= len;
    end else if (beat) begin
      remaining  <= remaining_dec;
      beats_left <= beats_left - W_LEN'(1);
      if (burst_last) begin
        // Next burst starts right after the one just drained.
        addr <= addr + ADDR_W'(len) * ADDR_W'(WORD_BYTES);
        len  <= clip_len(32'(remaining_dec), 32'(MAX_LEN));
      end
    end
  end

endmodule

// File: rtl/cnn_fb_loader.sv
// Filter-buffer loader. On fb_load_req it fetches the 3x3 weight tile of
// the requested output-channel tile (q_channel*KTAPS words) from external
// memory in bursts of at most MAX_BURST beats, writes every beat into the
// filter buffer in the cycle it arrives, then raises o_bm_csync_done for
// the layer controller.
//   q_base_addr/q_channel/q_chn_out : layer weight base, channel counts
//   fb_load_req, ctrl_csync_run     : controller handshake
//   o_bm_csync_done, o_busy         : status back to the controller
//   o_err_overlap                   : sticky, request seen while not idle
//   o_rd_req/addr/len, i_rd_ack     : memory read-request channel
//   i_rd_valid/data, o_rd_ready     : memory read-data channel
//   o_fb_we/waddr/wdata             : filter-buffer write port
module cnn_fb_loader
  import cnn_fb_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [W_ADDR-1:0]    q_base_addr,
  input  logic [W_CHANNEL-1:0] q_channel,
  input  logic [W_CHANNEL-1:0] q_chn_out,
  input  logic                 fb_load_req,
  input  logic                 ctrl_csync_run,
  output logic                 o_bm_csync_done,
  output logic                 o_busy,
  output logic                 o_err_overlap,
  output logic                 o_rd_req,
  output logic [W_ADDR-1:0]    o_rd_addr,
  output logic [W_LEN-1:0]     o_rd_len,
  input  logic                 i_rd_ack,
  input  logic                 i_rd_valid,
  input  logic [W_DATA-1:0]    i_rd_data,
  output logic                 o_rd_ready,
  output logic                 o_fb_we,
  output logic [W_FB_ADDR-1:0] o_fb_waddr,
  output logic [W_DATA-1:0]    o_fb_wdata
);

  localparam int W_TOTAL = W_CHANNEL + 4;
  // The write counter is one bit wider than the buffer address whenever a
  // tile could overrun it, so overflowing writes can be recognised.
  localparam int W_WCNT  = (W_TOTAL > W_FB_ADDR) ? W_TOTAL : W_FB_ADDR + 1;
  localparam int BYTES   = W_DATA / 8;

  fb_state_e          state;
  logic [W_TOTAL-1:0] total;
  logic [W_ADDR-1:0]  start_addr;
  logic [W_WCNT-1:0]  waddr;
  logic               start;
  logic               ack;
  logic               beat;
  logic               in_range;
  logic               burst_last;
  logic               final_word;

  // Tile geometry: each output-channel tile owns q_channel*KTAPS words.
  assign total      = W_TOTAL'(q_channel) * W_TOTAL'(KTAPS);
  assign start_addr = q_base_addr
                    + W_ADDR'(q_chn_out) * W_ADDR'(total) * W_ADDR'(BYTES);

  assign start = (state == S_IDLE) && fb_load_req;
  assign ack   = (state == S_REQ) && i_rd_ack;
  // o_rd_ready is only high in RECV, so stray beats elsewhere fall away.
  assign beat  = i_rd_valid && o_rd_ready;

  // Beats past the end of the buffer are consumed but never written.
  assign in_range   = ((waddr >> W_FB_ADDR) == '0);
  assign o_fb_we    = beat && in_range;
  assign o_fb_waddr = waddr[W_FB_ADDR-1:0];
  assign o_fb_wdata = o_fb_we ? i_rd_data : '0;

  cnn_burst_splitter #(
    .ADDR_W     (W_ADDR),
    .CNT_W      (W_TOTAL),
    .MAX_LEN    (MAX_BURST),
    .WORD_BYTES (BYTES)
  ) u_splitter (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .start_addr (start_addr),
    .total      (total),
    .ack        (ack),
    .beat       (beat),
    .addr       (o_rd_addr),
    .len        (o_rd_len),
    .burst_last (burst_last),
    .final_word (final_word)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= S_IDLE;
      waddr           <= '0;
      o_busy          <= 1'b0;
      o_rd_req        <= 1'b0;
      o_rd_ready      <= 1'b0;
      o_bm_csync_done <= 1'b0;
      o_err_overlap   <= 1'b0;
    end else begin
      if (fb_load_req && (state != S_IDLE)) o_err_overlap <= 1'b1;

      unique case (state)
        S_IDLE: begin
          if (fb_load_req) begin
            waddr <= '0;
            if (total == '0) begin
              state <= S_DONE;
            end else begin
              state    <= S_REQ;
              o_busy   <= 1'b1;
              o_rd_req <= 1'b1;
            end
          end
        end

        S_REQ: begin
          if (i_rd_ack) begin
            state      <= S_RECV;
            o_rd_req   <= 1'b0;
            o_rd_ready <= 1'b1;
          end
        end

        S_RECV: begin
          if (beat) begin
            waddr <= waddr + W_WCNT'(1);
            if (burst_last) begin
              o_rd_ready <= 1'b0;
              if (final_word) begin
                state  <= S_DONE;
                o_busy <= 1'b0;
              end else begin
                state    <= S_REQ;
                o_rd_req <= 1'b1;
              end
            end
          end
        end

        S_DONE: begin
          // First DONE cycle raises done; it then holds until the controller
          // leaves channel sync, giving a one-cycle pulse if it already has.
          if (!o_bm_csync_done) begin
            o_bm_csync_done <= 1'b1;
          end else if (!ctrl_csync_run) begin
            o_bm_csync_done <= 1'b0;
            state           <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_fb_loader.sv
// Directed bench for cnn_fb_loader: a small memory responder (configurable
// ack delay, random valid gaps, junk beats during the ack wait) and a
// negedge monitor that logs bursts, buffer writes and done timing.
module tb_cnn_fb_loader;
  import cnn_fb_loader_pkg::*;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [W_ADDR-1:0]    q_base_addr;
  logic [W_CHANNEL-1:0] q_channel;
  logic [W_CHANNEL-1:0] q_chn_out;
  logic                 fb_load_req;
  logic                 ctrl_csync_run;
  logic                 o_bm_csync_done;
  logic                 o_busy;
  logic                 o_err_overlap;
  logic                 o_rd_req;
  logic [W_ADDR-1:0]    o_rd_addr;
  logic [W_LEN-1:0]     o_rd_len;
  logic                 i_rd_ack;
  logic                 i_rd_valid;
  logic [W_DATA-1:0]    i_rd_data;
  logic                 o_rd_ready;
  logic                 o_fb_we;
  logic [W_FB_ADDR-1:0] o_fb_waddr;
  logic [W_DATA-1:0]    o_fb_wdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  cnn_fb_loader dut (
    .clk             (clk),
    .rstn            (rstn),
    .q_base_addr     (q_base_addr),
    .q_channel       (q_channel),
    .q_chn_out       (q_chn_out),
    .fb_load_req     (fb_load_req),
    .ctrl_csync_run  (ctrl_csync_run),
    .o_bm_csync_done (o_bm_csync_done),
    .o_busy          (o_busy),
    .o_err_overlap   (o_err_overlap),
    .o_rd_req        (o_rd_req),
    .o_rd_addr       (o_rd_addr),
    .o_rd_len        (o_rd_len),
    .i_rd_ack        (i_rd_ack),
    .i_rd_valid      (i_rd_valid),
    .i_rd_data       (i_rd_data),
    .o_rd_ready      (o_rd_ready),
    .o_fb_we         (o_fb_we),
    .o_fb_waddr      (o_fb_waddr),
    .o_fb_wdata      (o_fb_wdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents: each word is derived from its byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // ---------------- memory responder ----------------
  int          ack_delay = 0;
  bit          gaps      = 0;
  bit          garbage   = 0;
  logic [31:0] beat_q[$];

  initial begin : responder
    bit pop_pending;
    int ack_cnt;
    pop_pending = 0;
    ack_cnt     = 0;
    i_rd_ack    = 0;
    i_rd_valid  = 0;
    i_rd_data   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rstn) begin
        beat_q.delete();
        pop_pending = 0;
        ack_cnt     = 0;
        i_rd_ack    = 0;
        i_rd_valid  = 0;
        i_rd_data   = '0;
        continue;
      end
      if (pop_pending) void'(beat_q.pop_front());
      if (i_rd_ack) begin
        i_rd_ack = 0;
        ack_cnt  = 0;
      end else if (o_rd_req) begin
        if (ack_cnt >= ack_delay) begin
          i_rd_ack = 1;
          for (int k = 0; k < int'(o_rd_len); k++)
            beat_q.push_back(o_rd_addr + 32'(4 * k));
        end else begin
          ack_cnt++;
        end
      end
      if (beat_q.size() != 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
        i_rd_valid = 1;
        i_rd_data  = mem_word(beat_q[0]);
      end else if (garbage && o_rd_req) begin
        i_rd_valid = 1;
        i_rd_data  = 32'hDEAD_BEEF;
      end else begin
        i_rd_valid = 0;
        i_rd_data  = '0;
      end
      pop_pending = i_rd_valid && o_rd_ready && (beat_q.size() != 0);
    end
  end

  // ---------------- monitor ----------------
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  logic [31:0] br_addr_q[$];
  int          br_len_q[$];
  int          req_cycles    = 0;
  int          stab_viol     = 0;
  int          done_rise_cyc = -1;
  logic        prev_done     = 0;
  logic        prev_req      = 0;
  logic [31:0] prev_addr     = '0;
  logic [4:0]  prev_len      = '0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (o_fb_we) begin
        wr_addr_q.push_back(32'(o_fb_waddr));
        wr_data_q.push_back(o_fb_wdata);
        wr_cyc_q.push_back(cyc);
      end
      if (o_rd_req) begin
        req_cycles++;
        if (prev_req && (o_rd_addr !== prev_addr || o_rd_len !== prev_len))
          stab_viol++;
      end
      if (o_rd_req && i_rd_ack) begin
        br_addr_q.push_back(o_rd_addr);
        br_len_q.push_back(int'(o_rd_len));
      end
      if (o_bm_csync_done && !prev_done) done_rise_cyc = cyc;
      prev_done = o_bm_csync_done;
      prev_req  = o_rd_req;
      prev_addr = o_rd_addr;
      prev_len  = o_rd_len;
    end
  end

  // ---------------- helpers (stimulus / model only) ----------------
  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    br_addr_q.delete();
    br_len_q.delete();
    req_cycles    = 0;
    stab_viol     = 0;
    done_rise_cyc = -1;
  endtask

  task automatic start_load(input int ch, input int co, input logic [31:0] base);
    @(posedge clk);
    #1;
    q_channel   = W_CHANNEL'(ch);
    q_chn_out   = W_CHANNEL'(co);
    q_base_addr = base;
    fb_load_req = 1;
    @(posedge clk);
    #1;
    fb_load_req = 0;
  endtask

  // Mismatches between the logged writes and the expected contiguous tile.
  function automatic int count_bad_writes(input logic [31:0] base, input int n);
    int bad = 0;
    if (wr_addr_q.size() != n) return n + 1;
    for (int i = 0; i < n; i++)
      if (wr_addr_q[i] !== 32'(i) || wr_data_q[i] !== mem_word(base + 32'(4 * i)))
        bad++;
    return bad;
  endfunction

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (o_bm_csync_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (o_bm_csync_done !== 1'b1) begin
      errors++;
      $display("FAIL %s: done not seen within %0d cycles, got %b want 1", name, budget, o_bm_csync_done);
    end
  endtask

  task automatic release_done(input string name);
    int n = 0;
    @(posedge clk);
    #1;
    ctrl_csync_run = 0;
    while (o_bm_csync_done !== 1'b0 && n < 5) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (o_bm_csync_done !== 1'b0) begin
      errors++;
      $display("FAIL %s: done did not clear, got %b want 0", name, o_bm_csync_done);
    end
    @(posedge clk);
    #1;
    ctrl_csync_run = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 0;
    #1;
    checks++;
    if ({o_bm_csync_done, o_busy, o_err_overlap, o_rd_req, o_rd_ready, o_fb_we} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000",
               {o_bm_csync_done, o_busy, o_err_overlap, o_rd_req, o_rd_ready, o_fb_we});
    end
    checks++;
    if (o_rd_addr !== '0 || o_rd_len !== '0) begin
      errors++;
      $display("FAIL reset_rd: addr %h len %0d want 0/0", o_rd_addr, o_rd_len);
    end
    checks++;
    if (o_fb_waddr !== '0 || o_fb_wdata !== '0) begin
      errors++;
      $display("FAIL reset_fb: waddr %0d wdata %h want 0/0", o_fb_waddr, o_fb_wdata);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_rd_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy %b req %b want 0/0", o_busy, o_rd_req);
    end
  endtask

  task automatic test_two_channels();
    clear_logs();
    ack_delay = 0; gaps = 0; garbage = 0;
    start_load(2, 0, 32'h1000);
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_start: got %b want 1", o_busy);
    end
    wait_done(200, "two_ch_done");
    checks++;
    if (br_addr_q.size() != 2) begin
      errors++;
      $display("FAIL two_ch_bursts: got %0d bursts want 2", br_addr_q.size());
    end else begin
      checks++;
      if (br_addr_q[0] !== 32'h1000 || br_len_q[0] != 16) begin
        errors++;
        $display("FAIL two_ch_burst0: got %h/%0d want 1000/16", br_addr_q[0], br_len_q[0]);
      end
      checks++;
      if (br_addr_q[1] !== 32'h1040 || br_len_q[1] != 2) begin
        errors++;
        $display("FAIL two_ch_burst1: got %h/%0d want 1040/2", br_addr_q[1], br_len_q[1]);
      end
    end
    checks++;
    if (count_bad_writes(32'h1000, 18) != 0) begin
      errors++;
      $display("FAIL two_ch_writes: %0d writes, %0d bad, want 18 / 0",
               wr_addr_q.size(), count_bad_writes(32'h1000, 18));
    end
    checks++;
    if (done_rise_cyc - wr_cyc_q[$] != 2) begin
      errors++;
      $display("FAIL done_latency: got %0d cycles after last beat want 2", done_rise_cyc - wr_cyc_q[$]);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_in_done: got %b want 0", o_busy);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (o_bm_csync_done !== 1'b1) begin
      errors++;
      $display("FAIL done_hold: got %b want 1", o_bm_csync_done);
    end
    @(posedge clk);
    #1;
    ctrl_csync_run = 0;
    @(posedge clk);
    #1;
    checks++;
    if (o_bm_csync_done !== 1'b0) begin
      errors++;
      $display("FAIL done_clear: got %b want 0", o_bm_csync_done);
    end
    ctrl_csync_run = 1;
  endtask

  task automatic test_tile_offset(input bit with_gaps);
    clear_logs();
    ack_delay = with_gaps ? 5 : 0;
    gaps      = with_gaps;
    garbage   = with_gaps;
    start_load(4, 3, 32'h0);
    wait_done(600, "offset_done");
    checks++;
    if (br_addr_q.size() != 3) begin
      errors++;
      $display("FAIL offset_bursts: got %0d bursts want 3 (gaps=%0d)", br_addr_q.size(), with_gaps);
    end else begin
      checks++;
      if (br_addr_q[0] !== 32'h1B0 || br_len_q[0] != 16 ||
          br_addr_q[1] !== 32'h1F0 || br_len_q[1] != 16 ||
          br_addr_q[2] !== 32'h230 || br_len_q[2] != 4) begin
        errors++;
        $display("FAIL offset_burst_list: got %h/%0d %h/%0d %h/%0d want 1b0/16 1f0/16 230/4",
                 br_addr_q[0], br_len_q[0], br_addr_q[1], br_len_q[1], br_addr_q[2], br_len_q[2]);
      end
    end
    checks++;
    if (count_bad_writes(32'h1B0, 36) != 0) begin
      errors++;
      $display("FAIL offset_writes: %0d writes, %0d bad, want 36 / 0 (gaps=%0d)",
               wr_addr_q.size(), count_bad_writes(32'h1B0, 36), with_gaps);
    end
    checks++;
    if (wr_addr_q[$] !== 32'd35 || wr_data_q[$] !== 32'h5A5A_023C) begin
      errors++;
      $display("FAIL offset_last_write: got %0d/%h want 35/5a5a023c", wr_addr_q[$], wr_data_q[$]);
    end
    if (with_gaps) begin
      checks++;
      if (stab_viol != 0) begin
        errors++;
        $display("FAIL req_stable: got %0d changes during ack wait want 0", stab_viol);
      end
      checks++;
      if (req_cycles != 18) begin
        errors++;
        $display("FAIL req_cycles: got %0d want 18", req_cycles);
      end
    end
    checks++;
    if (o_err_overlap !== 1'b0) begin
      errors++;
      $display("FAIL no_overlap: got %b want 0", o_err_overlap);
    end
    release_done("offset_release");
  endtask

  task automatic test_overlap();
    int n = 0;
    clear_logs();
    ack_delay = 0; gaps = 0; garbage = 0;
    start_load(2, 0, 32'h1000);
    while (o_rd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    q_chn_out   = 5'd5;
    fb_load_req = 1;
    @(posedge clk);
    #1;
    fb_load_req = 0;
    wait_done(200, "overlap_done");
    checks++;
    if (o_err_overlap !== 1'b1) begin
      errors++;
      $display("FAIL overlap_flag: got %b want 1", o_err_overlap);
    end
    checks++;
    if (br_addr_q.size() != 2 || count_bad_writes(32'h1000, 18) != 0) begin
      errors++;
      $display("FAIL overlap_load: %0d bursts %0d writes, want 2 / 18 unchanged",
               br_addr_q.size(), wr_addr_q.size());
    end
    release_done("overlap_release");

    clear_logs();
    start_load(0, 0, 32'h1000);
    wait_done(10, "zero_done");
    checks++;
    if (req_cycles != 0 || wr_addr_q.size() != 0) begin
      errors++;
      $display("FAIL zero_load: req cycles %0d writes %0d want 0/0", req_cycles, wr_addr_q.size());
    end
    checks++;
    if (o_err_overlap !== 1'b1) begin
      errors++;
      $display("FAIL overlap_sticky: got %b want 1", o_err_overlap);
    end
    release_done("zero_release");
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    clear_logs();
    ack_delay = 0; gaps = 0; garbage = 0;
    start_load(4, 3, 32'h0);
    while (wr_addr_q.size() < 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #2;
    rstn = 0;
    #1;
    checks++;
    if ({o_bm_csync_done, o_busy, o_err_overlap, o_rd_req, o_rd_ready, o_fb_we} !== 6'b0 ||
        o_rd_addr !== '0 || o_fb_waddr !== '0 || o_fb_wdata !== '0) begin
      errors++;
      $display("FAIL reset_mid: flags %b addr %h waddr %0d wdata %h want all 0",
               {o_bm_csync_done, o_busy, o_err_overlap, o_rd_req, o_rd_ready, o_fb_we},
               o_rd_addr, o_fb_waddr, o_fb_wdata);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
    clear_logs();
    start_load(2, 0, 32'h1000);
    wait_done(200, "fresh_done");
    checks++;
    if (br_addr_q.size() != 2 || count_bad_writes(32'h1000, 18) != 0) begin
      errors++;
      $display("FAIL fresh_load: %0d bursts %0d writes first waddr %0d, want 2 / 18 / 0",
               br_addr_q.size(), wr_addr_q.size(), wr_addr_q.size() != 0 ? wr_addr_q[0] : 32'hFFFF_FFFF);
    end
    release_done("fresh_release");
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : main
    fb_load_req    = 0;
    ctrl_csync_run = 1;
    q_base_addr    = '0;
    q_channel      = '0;
    q_chn_out      = '0;
    test_reset();
    test_two_channels();
    test_tile_offset(1'b0);
    test_tile_offset(1'b1);
    test_overlap();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_fb_loader.md
Name: cnn_fb_loader

Overview:
- Filter-buffer loader directly upstream of the CNN layer controller, on its buffer-manager side.
- On each filter-load request, fetches the 3x3 weight tile for the current output-channel tile from external memory in bounded bursts. Writes the tile into the on-chip filter buffer.
- Returns bm_csync_done to the controller so it can leave its channel-sync phase.

Parameters:
- W_CHANNEL, 5, width of tiled channel counts/indices (matches controller).
- W_ADDR, 32, external memory byte-address width.
- W_DATA, 32, memory/filter-buffer word width (one word = one tap for one input-channel tile).
- KTAPS, 9, words per input-channel tile (3x3 kernel).
- MAX_BURST, 16, maximum beats per memory read request.
- W_FB_ADDR, 9, filter-buffer address width; depth must be at least KTAPS*2^W_CHANNEL words, else the tile is truncated (see Behaviour).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- q_base_addr  in  W_ADDR  byte base of this layer's weights; stable while busy
- q_channel  in  W_CHANNEL  tiled input-channel count
- q_chn_out  in  W_CHANNEL  output-channel tile to load; sampled on fb_load_req
- fb_load_req  in  1  one-cycle start pulse from controller
- ctrl_csync_run  in  1  controller is in channel-sync phase
- o_bm_csync_done  out  1  tile resident; held until ctrl_csync_run falls
- o_busy  out  1  load in progress
- o_err_overlap  out  1  sticky: fb_load_req arrived while busy
- o_rd_req  out  1  read-request valid
- o_rd_addr  out  W_ADDR  burst byte address
- o_rd_len  out  5  beats in burst, 1..MAX_BURST
- i_rd_ack  in  1  request accepted
- i_rd_valid  in  1  data beat valid
- i_rd_data  in  W_DATA  data beat
- o_rd_ready  out  1  loader accepts beat
- o_fb_we  out  1  filter-buffer write enable
- o_fb_waddr  out  W_FB_ADDR  write address
- o_fb_wdata  out  W_DATA  write data

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. Reset mid-load abandons the load; nothing is held pending.
- States: IDLE, REQ, RECV, DONE.
- IDLE
  - fb_load_req=1 latches total = q_channel*KTAPS (W_CHANNEL+4 bits), waddr=0, and addr = q_base_addr + q_chn_out*total*(W_DATA/8) (mod 2^W_ADDR).
  - Next state is REQ, or DONE if total==0. o_busy=1 from the next cycle.
- REQ
  - o_rd_req=1 with len = min(remaining, MAX_BURST); addr/len stable until i_rd_ack.
  - On the ack cycle: latch beat counter=len, go to RECV.
- RECV
  - o_rd_ready=1. Each i_rd_valid&o_rd_ready beat writes the filter buffer in the same cycle: o_fb_we=1, waddr, wdata=i_rd_data. Then waddr++, remaining--, beat counter--.
  - Beats arriving outside RECV are ignored; o_rd_ready=0 there.
  - After the last beat of a burst: go to REQ if remaining>0, else DONE. Next burst addr = previous addr + len*(W_DATA/8).
- DONE
  - o_busy=0, o_bm_csync_done=1. Hold while ctrl_csync_run=1; clear the cycle after ctrl_csync_run=0, then go to IDLE.
  - If ctrl_csync_run is already 0 on entry, done pulses for one cycle.
- Throughput: 1 word/cycle when i_rd_valid is continuous. Latency from req to done = bursts*(ack wait + len) + 2 cycles.
- fb_load_req while not IDLE: ignored, o_err_overlap<=1 (cleared only by reset). fb_load_req in DONE is also an overlap.
- Buffer overflow: writes with waddr >= 2^W_FB_ADDR are suppressed (o_fb_we=0), but beats are still consumed.
- The filter buffer is written only; the PE reads it during the data phase.

Decomposition:
- Shared package/header (controller_params.vh): W_CHANNEL, W_ADDR, W_DATA, KTAPS, MAX_BURST, state encodings.
- One natural sub-module: cnn_burst_splitter. It takes start address and total words and emits (addr, len) requests with per-burst countdown. Reusable by the psum writeback path.

Test Plan:
- q_channel=2, q_chn_out=0, base=0x1000, continuous valid, immediate ack.
  - One burst len=16 at 0x1000, then len=2 at 0x1040.
  - 18 fb writes at addr 0..17.
  - done rises 2 cycles after the last beat and holds until ctrl_csync_run falls.
- q_channel=4, q_chn_out=3, base=0.
  - First addr = 3*36*4 = 0x1B0.
  - Bursts 16,16,4.
  - Last write at waddr 35 with the final data.
- Random i_rd_valid gaps and ack delay of 5 cycles.
  - Write sequence and data are identical to the gap-free run.
  - o_rd_addr/len stay stable during the ack wait.
- fb_load_req pulsed mid-RECV: load completes unchanged, o_err_overlap=1 persists; q_channel=0 gives immediate done with no rd_req.
- rstn asserted mid-burst: all outputs 0 next edge. After release, a new fb_load_req performs a full fresh load starting at waddr 0.
